// File: rtl/irq_request_latch.sv
// Edge-capturing request latch that feeds a 4-input priority encoder. Optional macro IRQ_SYNC_EN adds a 2-flop input synchronizer.
// Latency: 1 edge from a sampled rising edge to pend_out, or 3 edges with IRQ_SYNC_EN. There is no backpressure; ack/clr_ovf are single-cycle strobes.
module irq_request_latch (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    input  logic [3:0] mask,
    input  logic       ack,
    input  logic [1:0] ack_idx,
    input  logic       clr_ovf,
    output logic [3:0] pend_out,
    output logic       irq,
    output logic [3:0] overflow
);

    logic [3:0] r_req_prev;
    logic [3:0] r_pending;
    logic [3:0] r_overflow;
    logic [3:0] r_pend_out;
    logic       r_irq;

    logic [3:0] w_req_s;
    logic [3:0] w_edge;
    logic [3:0] w_clr;
    logic [3:0] w_pending_next;
    logic [3:0] w_ovf_set;
    logic [3:0] w_overflow_next;
    logic [3:0] w_visible;

`ifdef IRQ_SYNC_EN
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    // Reset to ones so lines held high through reset do not look like edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= req_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_req_s = r_sync2;
`else
    assign w_req_s = req_in;
`endif

    assign w_edge = w_req_s & ~r_req_prev;
    assign w_clr  = ack ? (4'b0001 << ack_idx) : 4'b0000;

    // A new edge always leaves the bit pending, even when the old event is acked in the same cycle.
    assign w_pending_next  = w_edge | (r_pending & ~w_clr);
    assign w_ovf_set       = w_edge & r_pending & ~w_clr;
    assign w_overflow_next = (r_overflow & ~{4{clr_ovf}}) | w_ovf_set;
    assign w_visible       = w_pending_next & ~mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_prev <= 4'b1111;
            r_pending  <= 4'b0000;
            r_overflow <= 4'b0000;
            r_pend_out <= 4'b0000;
            r_irq      <= 1'b0;
        end else begin
            r_req_prev <= w_req_s;
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
            r_pend_out <= w_visible;
            r_irq      <= |w_visible;
        end
    end

    assign pend_out = r_pend_out;
    assign irq      = r_irq;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch; request latency follows IRQ_SYNC_EN.
module tb_irq_request_latch;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_idx;
    logic       clr_ovf;
    logic [3:0] pend_out;
    logic       irq;
    logic [3:0] overflow;

    int checks = 0;
    int errors = 0;

    irq_request_latch dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .mask     (mask),
        .ack      (ack),
        .ack_idx  (ack_idx),
        .clr_ovf  (clr_ovf),
        .pend_out (pend_out),
        .irq      (irq),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_ack(input logic [1:0] idx);
        ack     = 1'b1;
        ack_idx = idx;
        tick(1);
        ack     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_in = 4'b1111; mask = 4'b0000;
        ack = 1'b0; ack_idx = 2'd0; clr_ovf = 1'b0;
        tick(3);
        check("rst_pend", pend_out, 4'b0000);
        check("rst_irq", {3'b000, irq}, 4'b0000);
        check("rst_ovf", overflow, 4'b0000);

        // Lines high across reset release must not register as edges.
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check("release_pend", pend_out, 4'b0000);
            check("release_irq", {3'b000, irq}, 4'b0000);
        end

        // Basic capture and acknowledge.
        req_in = 4'b0000;
        tick(LAT + 2);
        req_in = 4'b0101;
        tick(LAT - 1);
        check("cap_before", pend_out, 4'b0000);
        tick(1);
        check("cap_pend", pend_out, 4'b0101);
        check("cap_irq", {3'b000, irq}, 4'b0001);
        do_ack(2'd2);
        check("ack2_pend", pend_out, 4'b0001);
        do_ack(2'd0);
        check("ack0_pend", pend_out, 4'b0000);
        check("ack0_irq", {3'b000, irq}, 4'b0000);

        // Two edges on bit 3 without ack -> overflow.
        req_in = 4'b0000;
        tick(LAT);
        req_in = 4'b1000;
        tick(LAT);
        check("ovf_first_pend", pend_out, 4'b1000);
        check("ovf_first_ovf", overflow, 4'b0000);
        req_in = 4'b0000;
        tick(1);
        req_in = 4'b1000;
        tick(LAT);
        check("ovf_second_ovf", overflow, 4'b1000);
        check("ovf_second_pend", pend_out, 4'b1000);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("clr_ovf_ovf", overflow, 4'b0000);
        check("clr_ovf_pend", pend_out, 4'b1000);

        // Edge on bit 1 coinciding with its ack: stays pending, no overflow.
        req_in = 4'b1010;
        tick(LAT);
        check("b1_pend", pend_out, 4'b1010);
        req_in = 4'b1000;
        tick(LAT);
        req_in = 4'b1010;
        tick(LAT - 1);
        do_ack(2'd1);
        check("edge_ack_pend", pend_out, 4'b1010);
        check("edge_ack_ovf", overflow, 4'b0000);

        // Ack of a non-pending index changes nothing.
        do_ack(2'd0);
        check("ack_idle_pend", pend_out, 4'b1010);
        check("ack_idle_ovf", overflow, 4'b0000);

        // Masked capture, then unmask reveals it.
        do_ack(2'd3);
        do_ack(2'd1);
        check("drain_pend", pend_out, 4'b0000);
        req_in = 4'b0000;
        tick(LAT);
        mask = 4'b0010;
        req_in = 4'b0010;
        tick(LAT);
        check("masked_pend", pend_out, 4'b0000);
        check("masked_irq", {3'b000, irq}, 4'b0000);
        mask = 4'b0000;
        tick(1);
        check("unmask_pend", pend_out, 4'b0010);
        check("unmask_irq", {3'b000, irq}, 4'b0001);

        // Build pend_out=1111 and overflow=0100, then reset mid-operation.
        do_ack(2'd1);
        req_in = 4'b0000;
        tick(LAT);
        req_in = 4'b1111;
        tick(LAT);
        req_in = 4'b1011;
        tick(LAT);
        req_in = 4'b1111;
        tick(LAT);
        check("full_pend", pend_out, 4'b1111);
        check("full_ovf", overflow, 4'b0100);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_pend", pend_out, 4'b0000);
        check("midrst_irq", {3'b000, irq}, 4'b0000);
        check("midrst_ovf", overflow, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
